// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative CORDIC vectoring engine: (x, y) to (angle, magnitude)
module cordic_vectoring #(
    parameter int ITER = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic signed [15:0] i_x_in,
    input  logic signed [15:0] i_y_in,
    output logic               o_busy,
    output logic               o_done,
    output logic signed [15:0] o_angle_out,
    output logic        [15:0] o_mag_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRE   = 2'd1,
        S_ITER  = 2'd2,
        S_SCALE = 2'd3
    } state_t;

    localparam logic signed [15:0] PI_Q13      = 16'sd25736;
    localparam logic signed [15:0] HALF_PI_Q13 = 16'sd12868;

    state_t             r_state;
    state_t             w_state_next;
    logic signed [17:0] r_x;
    logic signed [17:0] r_y;
    logic signed [15:0] r_z;
    logic        [3:0]  r_iter;
    logic               r_zero;
    logic               r_done;
    logic signed [15:0] r_angle;
    logic        [15:0] r_mag;

    logic signed [15:0] w_atan;
    logic signed [17:0] w_x_sh;
    logic signed [17:0] w_y_sh;
    logic signed [35:0] w_prod;
    logic signed [35:0] w_mag_full;
    logic        [15:0] w_mag_sat;
    logic signed [15:0] w_angle_wrap;

    // arctan(2^-i) in Q3.13, rounded; the last two entries round to zero
    always_comb begin
        w_atan = 16'sd0;
        case (r_iter)
            4'd0:    w_atan = 16'sd6434;
            4'd1:    w_atan = 16'sd3798;
            4'd2:    w_atan = 16'sd2007;
            4'd3:    w_atan = 16'sd1019;
            4'd4:    w_atan = 16'sd511;
            4'd5:    w_atan = 16'sd256;
            4'd6:    w_atan = 16'sd128;
            4'd7:    w_atan = 16'sd64;
            4'd8:    w_atan = 16'sd32;
            4'd9:    w_atan = 16'sd16;
            4'd10:   w_atan = 16'sd8;
            4'd11:   w_atan = 16'sd4;
            4'd12:   w_atan = 16'sd2;
            4'd13:   w_atan = 16'sd1;
            default: w_atan = 16'sd0;
        endcase
    end

    // gain compensation with rounding, clamp to the unsigned output range, and fold -pi onto +pi
    always_comb begin
        w_x_sh       = r_x >>> r_iter;
        w_y_sh       = r_y >>> r_iter;
        w_prod       = $signed({{18{r_x[17]}}, r_x}) * 36'sd19898 + 36'sd16384;
        w_mag_full   = w_prod >>> 15;
        w_mag_sat    = w_mag_full[15:0];
        if (w_mag_full < 36'sd0) begin
            w_mag_sat = 16'd0;
        end else if (w_mag_full > 36'sd65535) begin
            w_mag_sat = 16'hFFFF;
        end
        w_angle_wrap = (r_z <= -PI_Q13) ? PI_Q13 : r_z;
    end

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state logic: start is only looked at in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_PRE;
            S_PRE:   w_state_next = S_ITER;
            S_ITER:  if (r_iter == 4'(ITER - 1)) w_state_next = S_SCALE;
            S_SCALE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // outputs: busy follows the state, done and results come from registers
    always_comb begin
        o_busy      = (r_state != S_IDLE);
        o_done      = r_done;
        o_angle_out = r_angle;
        o_mag_out   = r_mag;
    end

    // datapath: load, quadrant fold, micro-rotations, scaling
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x     <= 18'sd0;
            r_y     <= 18'sd0;
            r_z     <= 16'sd0;
            r_iter  <= 4'd0;
            r_zero  <= 1'b0;
            r_done  <= 1'b0;
            r_angle <= 16'sd0;
            r_mag   <= 16'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_x    <= {{2{i_x_in[15]}}, i_x_in};
                        r_y    <= {{2{i_y_in[15]}}, i_y_in};
                        r_z    <= 16'sd0;
                        r_zero <= (i_x_in == 16'sd0) && (i_y_in == 16'sd0);
                    end
                end
                S_PRE: begin
                    if (r_x < 18'sd0 && r_y >= 18'sd0) begin
                        r_x <= r_y;
                        r_y <= -r_x;
                        r_z <= HALF_PI_Q13;
                    end else if (r_x < 18'sd0) begin
                        r_x <= -r_y;
                        r_y <= r_x;
                        r_z <= -HALF_PI_Q13;
                    end
                    r_iter <= 4'd0;
                end
                S_ITER: begin
                    if (r_y >= 18'sd0) begin
                        r_x <= r_x + w_y_sh;
                        r_y <= r_y - w_x_sh;
                        r_z <= r_z + w_atan;
                    end else begin
                        r_x <= r_x - w_y_sh;
                        r_y <= r_y + w_x_sh;
                        r_z <= r_z - w_atan;
                    end
                    r_iter <= r_iter + 4'd1;
                end
                S_SCALE: begin
                    r_mag   <= r_zero ? 16'd0 : w_mag_sat;
                    r_angle <= r_zero ? 16'sd0 : w_angle_wrap;
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb/tb_cordic_vectoring.sv - scoreboard bench for cordic_vectoring with directed vectors
module tb_cordic_vectoring;

    logic               clk;
    logic               rst;
    logic               start;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic               busy;
    logic               done;
    logic signed [15:0] angle_out;
    logic        [15:0] mag_out;

    typedef struct {
        int     ang;
        int     mag;
        int     tol;
        longint cyc;
    } exp_t;

    exp_t   sb[$];
    longint cyc;
    int     n_cmp;
    int     n_bad;
    int     done_cnt;

    cordic_vectoring #(.ITER(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_x_in      (x_in),
        .i_y_in      (y_in),
        .o_busy      (busy),
        .o_done      (done),
        .o_angle_out (angle_out),
        .o_mag_out   (mag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint lo, input longint hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0, 0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc, e.cyc);
                chk("angle", int'(angle_out), e.ang - e.tol, e.ang + e.tol);
                chk("mag", int'(mag_out), e.mag - e.tol, e.mag + e.tol);
            end
        end
    end

    task automatic push_exp(input int ang, input int mag, input int tol, input longint at);
        exp_t e;
        e.ang = ang;
        e.mag = mag;
        e.tol = tol;
        e.cyc = at;
        sb.push_back(e);
    endtask

    // one operation; optional stray start pulses at E5 and E10
    task automatic run_vec(input logic [15:0] xv, input logic [15:0] yv,
                           input int ang, input int mag, input int tol, input bit stray);
        @(negedge clk);
        x_in  = xv;
        y_in  = yv;
        start = 1'b1;
        push_exp(ang, mag, tol, cyc + 19);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            start = stray && (k == 5 || k == 10);
            x_in  = 16'($urandom);
            y_in  = 16'($urandom);
            if (k == 1) chk("busy_after_start", longint'(busy), 1, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint c0;
        int     dc;
        n_cmp    = 0;
        n_bad    = 0;
        done_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        x_in     = 16'sd0;
        y_in     = 16'sd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", longint'(busy), 0, 0);
        chk("rst_done", longint'(done), 0, 0);
        chk("rst_angle", longint'(angle_out), 0, 0);
        chk("rst_mag", longint'(mag_out), 0, 0);
        rst = 1'b0;

        run_vec(16'h4000, 16'h0000,      0, 16384, 4, 1'b0);
        run_vec(16'h0000, 16'h4000,  12868, 16384, 4, 1'b0);
        run_vec(16'h4000, 16'h4000,   6434, 23170, 4, 1'b0);
        run_vec(16'hC000, 16'hC000, -19302, 23170, 4, 1'b0);
        run_vec(16'hC000, 16'h4000,  19302, 23170, 4, 1'b0);
        run_vec(16'h4000, 16'hC000,  -6434, 23170, 4, 1'b0);
        run_vec(16'h2000, 16'h6000,  10232, 25906, 4, 1'b0);
        run_vec(16'hC000, 16'h0000,  25736, 16384, 4, 1'b0);
        run_vec(16'h0000, 16'h0000,      0,     0, 0, 1'b0);
        run_vec(16'h8000, 16'h8000, -19302, 46341, 4, 1'b0);
        run_vec(16'h8000, 16'h0000,  25736, 32768, 4, 1'b0);
        run_vec(16'h4000, 16'h4000,   6434, 23170, 4, 1'b1);

        // start held high: accepted at E0, E19 and E38 of the window
        @(negedge clk);
        c0    = cyc;
        x_in  = 16'h0000;
        y_in  = 16'h4000;
        start = 1'b1;
        push_exp(12868, 16384, 4, c0 + 19);
        push_exp(12868, 16384, 4, c0 + 38);
        push_exp(12868, 16384, 4, c0 + 57);
        repeat (40) @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        chk("sb_drained_after_hold", longint'(sb.size()), 0, 0);

        // asynchronous reset in the middle of ITER
        @(negedge clk);
        x_in  = 16'h4000;
        y_in  = 16'h4000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", longint'(busy), 0, 0);
        chk("async_rst_done", longint'(done), 0, 0);
        chk("async_rst_angle", longint'(angle_out), 0, 0);
        chk("async_rst_mag", longint'(mag_out), 0, 0);
        @(negedge clk);
        rst = 1'b0;
        dc  = done_cnt;
        repeat (25) @(negedge clk);
        chk("no_done_after_abort", longint'(done_cnt), longint'(dc), longint'(dc));
        chk("sb_empty_at_end", longint'(sb.size()), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
